// File: rtl/arith_arbiter_pkg.sv
// Shared types for the arithmetic arbiter: operand/result widths, opcodes,
// FSM states, default latencies and opcode-class helpers.
package arith_arbiter_pkg;

  typedef logic [63:0]  quad_t;
  typedef logic [127:0] bquad_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_CMP  = 4'd5,
    OP_AADD = 4'd6,
    OP_ASUB = 4'd7,
    OP_AMUL = 4'd8,
    OP_ADIV = 4'd9,
    OP_AMOD = 4'd10
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_MUL_CYCLES = 3;
  localparam int unsigned DEF_DIV_CYCLES = 8;

  function automatic logic is_single_op(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AADD, OP_ASUB, OP_CMP};
  endfunction

  function automatic logic is_mul_op(opcode_t op);
    return op inside {OP_MUL, OP_AMUL};
  endfunction

  function automatic logic is_div_op(opcode_t op);
    return op inside {OP_DIV, OP_MOD, OP_ADIV, OP_AMOD};
  endfunction

endpackage

// File: rtl/arith_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester not granted last; the history only moves when update is high.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (valid)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant     = last ? 2'b01 : 2'b10;
        grant_idx = ~last;
      end
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/arith_arbiter.sv
// Shares one external combinational arithmetic unit between the execute pipe
// (requester 0) and the address unit (requester 1), holding each op for its latency.
module arith_arbiter
  import arith_arbiter_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  opcode_t    req_op [2],
  input  quad_t      req_a  [2],
  input  quad_t      req_b  [2],
  output logic [1:0] resp_valid,
  input  logic [1:0] resp_ready,
  output bquad_t     resp_result,
  output logic       resp_err,
  output opcode_t    arith_op,
  output quad_t      arith_a,
  output quad_t      arith_b,
  input  bquad_t     arith_result
);

  localparam int unsigned MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  state_e           state;
  logic [CNT_W-1:0] count;
  logic             owner;
  logic [1:0]       grant;
  logic             grant_idx;
  logic             accept;
  logic             op_err;

  // Remaining EXEC cycles after acceptance; errors complete after one cycle.
  function automatic logic [CNT_W-1:0] exec_count(opcode_t op, quad_t b);
    if (is_mul_op(op)) return CNT_W'(MUL_CYCLES - 1);
    if (is_div_op(op) && (b != '0)) return CNT_W'(DIV_CYCLES - 1);
    return '0;
  endfunction

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = (rst_n && (state == S_IDLE)) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign op_err = !(is_single_op(arith_op) || is_mul_op(arith_op) || is_div_op(arith_op)) ||
                  (is_div_op(arith_op) && (arith_b == '0));

  always_ff @(posedge clk) begin
    // NOTE: the captured operands are reset too, since they are visible outputs.
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      owner       <= 1'b0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_err    <= 1'b0;
      arith_op    <= OP_ADD;
      arith_a     <= '0;
      arith_b     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            arith_op <= req_op[grant_idx];
            arith_a  <= req_a[grant_idx];
            arith_b  <= req_b[grant_idx];
            owner    <= grant_idx;
            count    <= exec_count(req_op[grant_idx], req_b[grant_idx]);
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (count == '0) begin
            resp_result <= op_err ? '0 : arith_result;
            resp_err    <= op_err;
            resp_valid  <= owner ? 2'b10 : 2'b01;
            state       <= S_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready[owner]) begin
            resp_valid <= 2'b00;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/arith_arbiter.md
ARITH_ARBITER -- requirements
Module: arith_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, meaning the EXEC cycles held for MUL/AMUL.
REQ-002 SHALL have parameter DIV_CYCLES, default 8, meaning the EXEC cycles held for DIV/MOD/ADIV/AMOD.
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port req_valid  in  2  per-requester request valid; requester 0 = execute pipe, requester 1 = address unit.
REQ-006 SHALL have port req_ready  out  2  per-requester accept.
REQ-007 SHALL have port req_op  in  2 x opcode_t  per-requester opcode.
REQ-008 SHALL have port req_a, req_b  in  2 x quad_t (64)  per-requester operands.
REQ-009 SHALL have port resp_valid  out  2  per-requester response valid.
REQ-010 SHALL have port resp_ready  in  2  per-requester response accept.
REQ-011 SHALL have port resp_result  out  bquad_t  result, shared by both requesters, qualified by resp_valid.
REQ-012 SHALL have port resp_err  out  1  unsupported opcode or divide by zero, qualified by resp_valid.
REQ-013 SHALL have port arith_op  out  opcode_t, and arith_a, arith_b  out  quad_t, driving the shared combinational arithmetic unit.
REQ-014 SHALL have port arith_result  in  bquad_t  result from the arithmetic unit.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-016 In IDLE, SHALL assert req_ready for at most one requester, combinationally: the sole valid requester, or, if both are valid, the requester not granted last (round-robin).
REQ-017 On req_valid&req_ready, SHALL capture op, a, b and the owner index into registers and go to EXEC; arith_* SHALL be driven only from these registers.
REQ-018 SHALL use an EXEC latency L of 1 for ADD/SUB/AADD/ASUB/CMP, MUL_CYCLES for MUL/AMUL, and DIV_CYCLES for DIV/MOD/ADIV/AMOD.
REQ-019 Down-counter: loaded with L-1 at acceptance and decremented each EXEC cycle; at zero, SHALL register arith_result into resp_result, set resp_err=0 and go to DONE.
REQ-020 Div-class op with b==0: SHALL use L=1 and force resp_result=0, resp_err=1, ignoring arith_result.
REQ-021 Any other opcode: SHALL use L=1 with resp_result=0, resp_err=1.
REQ-022 In DONE, SHALL assert resp_valid only to the owner, holding resp_result and resp_err stable until resp_ready of the owner, then go to IDLE.
REQ-023 resp_ready of the non-owner SHALL be ignored; req_ready SHALL be 0 in EXEC and DONE.
REQ-024 SHALL update the last-grant pointer only on acceptance.
REQ-025 Timing: acceptance at edge T, resp_valid high from edge T+L, next acceptance no earlier than one cycle after the response handshake.
REQ-026 Requests deasserted before acceptance SHALL leave no state change.

Reset
REQ-027 When rst_n=0 at a clock edge, SHALL force: state IDLE; req_ready=0 during reset; resp_valid=0; resp_result=0; resp_err=0; counter=0; arith_op=ADD; arith_a=arith_b=0; last-grant=1 (requester 0 wins first tie).
REQ-028 Reset in EXEC or DONE SHALL abandon the operation without a response.

Structure
REQ-029 SHALL keep opcode_t, quad_t and bquad_t in defines; SHALL add the FSM state enum and default latency constants to defines.
REQ-030 SHALL contain one sub-module, rr_arbiter2: 2-way round-robin grant with last-grant register and update enable.
REQ-031 SHALL leave the arithmetic unit outside this block, connected by the parent.

Verification
REQ-032 Directed test: req0 ADD a=5, b=7 alone -> req_ready[0] same cycle; resp_valid[0] one cycle later with resp_result=12, resp_err=0.
REQ-033 Directed test: both valid in the first cycle after reset, SUB 9-4 on req0 and MUL 3*4 on req1 -> req0 served first (result 5), then req1 (result 12); resp_valid[1] asserts 3 cycles after its acceptance.
REQ-034 Directed test: req1 DIV a=100, b=0 -> response after 1 cycle with resp_result=0, resp_err=1; arith_result ignored.
REQ-035 Directed test: req0 MOD 17%5 with resp_ready[0] held low 4 cycles -> resp_valid[0] and value 2 held stable throughout; no new grant until the handshake.
REQ-036 Directed test: rst_n low in EXEC cycle 3 of a DIV -> next cycle IDLE, all outputs at reset values, no resp_valid.
REQ-037 Directed test: both requesters issue continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
